fsm_seq_counter: RTL and testbench

//  Multi-channel Moore sequence counter. It arbitrates NCH request inputs and

---
 rtl/fsm_pkg.sv | 16 +
 rtl/seq_timer.sv | 26 ++
 rtl/fsm_seq_counter.sv | 115 +++++++++++
 tb/tb_fsm_seq_counter.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/fsm_pkg.sv
// Shared definitions for the sequence counter: one-hot state encoding and a width helper.
package fsm_pkg;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_RUN   = 4'b0010,
    ST_DONE  = 4'b0100,
    ST_ABORT = 4'b1000
  } state_e;

  // Minimum of one bit, so degenerate parameters still yield legal vectors.
  function automatic int clogw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seq_timer.sv
// Idle-cycle timer for RUN: counts up while enabled, saturates at TIMEOUT, clear has priority.
module seq_timer
  import fsm_pkg::*;
#(
  parameter int TIMEOUT = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int TW = clogw(TIMEOUT + 1);

  logic [TW-1:0] tmr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                               tmr <= '0;
    else if (clr)                             tmr <= '0;
    else if (en && (tmr != TW'(TIMEOUT)))     tmr <= tmr + 1'b1;
  end

  assign expired = (tmr == TW'(TIMEOUT));

endmodule

// File: rtl/fsm_seq_counter.sv
// Multi-channel Moore sequence counter: locks onto the highest-priority requester
// and counts DEPTH qualifying cycles, flagging done or abort for one cycle.
module fsm_seq_counter
  import fsm_pkg::*;
#(
  parameter int NCH     = 2,
  parameter int DEPTH   = 4,
  parameter int STRICT  = 0,
  parameter int TIMEOUT = 0,
  localparam int CW     = clogw(NCH),
  localparam int DW     = clogw(DEPTH)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [NCH-1:0] req,
  output logic           busy,
  output logic [CW-1:0]  chan,
  output logic [DW-1:0]  cnt,
  output logic           done,
  output logic           abort
);

  state_e        state, state_nx;
  logic [CW-1:0] chan_nx, pick;
  logic [DW-1:0] cnt_nx;
  logic          own, foreign, kill, expired;

  // Priority encoder: lowest index wins.
  always_comb begin
    pick = '0;
    for (int i = NCH - 1; i >= 0; i--)
      if (req[i]) pick = CW'(i);
  end

  always_comb begin
    own     = 1'b0;
    foreign = 1'b0;
    for (int i = 0; i < NCH; i++)
      if (req[i]) begin
        if (chan == CW'(i)) own     = 1'b1;
        else                foreign = 1'b1;
      end
  end

  assign kill = ((STRICT != 0) && foreign) || expired;

  generate
    if (TIMEOUT != 0) begin : g_tmr
      logic in_run;
      assign in_run = (state == ST_RUN);
      seq_timer #(.TIMEOUT(TIMEOUT)) u_tmr (
        .clk     (clk),
        .reset   (reset),
        .clr     (!in_run || own),
        .en      (in_run && !own),
        .expired (expired)
      );
    end else begin : g_no_tmr
      assign expired = 1'b0;
    end
  endgenerate

  always_comb begin
    state_nx = state;
    chan_nx  = chan;
    cnt_nx   = cnt;
    unique case (state)
      ST_IDLE: if (|req) begin
        state_nx = ST_RUN;
        chan_nx  = pick;
        cnt_nx   = '0;
      end
      ST_RUN: begin
        // Abort beats counting, even on the final qualifying cycle.
        if (kill) begin
          state_nx = ST_ABORT;
          cnt_nx   = '0;
        end else if (own) begin
          if (cnt == DW'(DEPTH - 1)) begin
            state_nx = ST_DONE;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
      end
      ST_DONE, ST_ABORT: begin
        state_nx = ST_IDLE;
        chan_nx  = '0;
      end
      default: begin
        state_nx = ST_IDLE;
        chan_nx  = '0;
        cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      chan  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      chan  <= chan_nx;
      cnt   <= cnt_nx;
    end
  end

  assign busy  = (state == ST_RUN);
  assign done  = (state == ST_DONE);
  assign abort = (state == ST_ABORT);

endmodule

// File: tb/tb_fsm_seq_counter.sv
// Directed bench: four parameterisations of fsm_seq_counter driven from vector tables
// and short hand-written sequences.
module tb_fsm_seq_counter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // d0: defaults; d1: STRICT=1; d2: TIMEOUT=3; d3: NCH=4 DEPTH=1
  logic [1:0] r0, r1, r2;
  logic [3:0] r3;
  logic       b0, b1, b2, b3, dn0, dn1, dn2, dn3, a0, a1, a2, a3;
  logic [0:0] c0, c1, c2;
  logic [1:0] c3;
  logic [1:0] n0, n1, n2;
  logic [0:0] n3;

  fsm_seq_counter u_d0 (.clk(clk), .reset(reset), .req(r0), .busy(b0), .chan(c0), .cnt(n0), .done(dn0), .abort(a0));
  fsm_seq_counter #(.STRICT(1)) u_d1 (.clk(clk), .reset(reset), .req(r1), .busy(b1), .chan(c1), .cnt(n1), .done(dn1), .abort(a1));
  fsm_seq_counter #(.TIMEOUT(3)) u_d2 (.clk(clk), .reset(reset), .req(r2), .busy(b2), .chan(c2), .cnt(n2), .done(dn2), .abort(a2));
  fsm_seq_counter #(.NCH(4), .DEPTH(1)) u_d3 (.clk(clk), .reset(reset), .req(r3), .busy(b3), .chan(c3), .cnt(n3), .done(dn3), .abort(a3));

  int passed = 0;
  int total  = 0;

  // Outputs packed as decimal digits: busy done abort chan cnt
  function automatic int pk(input int b, input int d, input int a, input int ch, input int cn);
    return b * 10000 + d * 1000 + a * 100 + ch * 10 + cn;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %05d expected %05d (busy done abort chan cnt)", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [1:0] req;
    int         exp;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [1:0] r, input int b, input int d, input int a, input int ch, input int cn);
    vec_t v;
    v.req = r;
    v.exp = pk(b, d, a, ch, cn);
    tbl.push_back(v);
  endtask

  task automatic s1(input string nm, input logic [1:0] r, input int e);
    r1 = r; tick();
    chk(nm, pk(b1, dn1, a1, c1, n1), e);
  endtask

  task automatic s2(input string nm, input logic [1:0] r, input int e);
    r2 = r; tick();
    chk(nm, pk(b2, dn2, a2, c2, n2), e);
  endtask

  task automatic s3(input string nm, input logic [3:0] r, input int e);
    r3 = r; tick();
    chk(nm, pk(b3, dn3, a3, c3, n3), e);
  endtask

  initial begin
    // basic count with a gap
    add(2'b01, 1,0,0,0,0); add(2'b01, 1,0,0,0,1); add(2'b00, 1,0,0,0,1);
    add(2'b01, 1,0,0,0,2); add(2'b01, 1,0,0,0,3); add(2'b01, 0,1,0,0,0);
    add(2'b00, 0,0,0,0,0);
    // req=11 picks ch0, foreign req ignored with STRICT=0
    add(2'b11, 1,0,0,0,0); add(2'b01, 1,0,0,0,1); add(2'b01, 1,0,0,0,2);
    add(2'b11, 1,0,0,0,3); add(2'b11, 0,1,0,0,0); add(2'b00, 0,0,0,0,0);
    // ch1 sequence; req in DONE ignored; restart
    add(2'b10, 1,0,0,1,0); add(2'b10, 1,0,0,1,1); add(2'b10, 1,0,0,1,2);
    add(2'b00, 1,0,0,1,2); add(2'b10, 1,0,0,1,3); add(2'b10, 0,1,0,1,0);
    add(2'b01, 0,0,0,0,0); add(2'b01, 1,0,0,0,0); add(2'b00, 1,0,0,0,0);

    reset = 1'b0;
    r0 = 2'b11; r1 = 2'b11; r2 = 2'b11; r3 = 4'b1111;
    repeat (3) tick();
    chk("rst_d0", pk(b0, dn0, a0, c0, n0), 0);
    chk("rst_d1", pk(b1, dn1, a1, c1, n1), 0);
    chk("rst_d2", pk(b2, dn2, a2, c2, n2), 0);
    chk("rst_d3", pk(b3, dn3, a3, c3, n3), 0);
    r0 = '0; r1 = '0; r2 = '0; r3 = '0;
    reset = 1'b1;

    foreach (tbl[i]) begin
      r0 = tbl[i].req;
      tick();
      chk($sformatf("tbl%0d", i), pk(b0, dn0, a0, c0, n0), tbl[i].exp);
    end

    // d0 is in RUN: asynchronous reset clears it between edges
    #2 reset = 1'b0;
    #1 chk("async_rst", pk(b0, dn0, a0, c0, n0), 0);
    #1 reset = 1'b1;
    r0 = '0;

    // STRICT: foreign req at cnt=2, then at the final count
    s1("st_a0", 2'b01, pk(1,0,0,0,0));
    s1("st_a1", 2'b01, pk(1,0,0,0,1));
    s1("st_a2", 2'b01, pk(1,0,0,0,2));
    s1("st_ab", 2'b11, pk(0,0,1,0,0));
    s1("st_id", 2'b00, 0);
    s1("st_b0", 2'b01, pk(1,0,0,0,0));
    s1("st_b1", 2'b01, pk(1,0,0,0,1));
    s1("st_b2", 2'b01, pk(1,0,0,0,2));
    s1("st_b3", 2'b01, pk(1,0,0,0,3));
    s1("st_fin", 2'b11, pk(0,0,1,0,0));
    s1("st_id2", 2'b00, 0);

    // TIMEOUT=3: three idle cycles arm the timer, abort on the next edge
    s2("to_run", 2'b01, pk(1,0,0,0,0));
    s2("to_t1",  2'b00, pk(1,0,0,0,0));
    s2("to_t2",  2'b00, pk(1,0,0,0,0));
    s2("to_t3",  2'b00, pk(1,0,0,0,0));
    s2("to_ab",  2'b00, pk(0,0,1,0,0));
    s2("to_id",  2'b00, 0);
    s2("tp_run", 2'b01, pk(1,0,0,0,0));
    s2("tp_t1",  2'b00, pk(1,0,0,0,0));
    s2("tp_t2",  2'b00, pk(1,0,0,0,0));
    s2("tp_pul", 2'b01, pk(1,0,0,0,1));
    s2("tp_u1",  2'b00, pk(1,0,0,0,1));
    s2("tp_u2",  2'b00, pk(1,0,0,0,1));
    s2("tp_c2",  2'b01, pk(1,0,0,0,2));
    s2("tp_c3",  2'b01, pk(1,0,0,0,3));
    s2("tp_dn",  2'b01, pk(0,1,0,0,0));
    s2("tp_id",  2'b00, 0);

    // DEPTH=1, NCH=4: back-to-back sequences on ch3, then ch1 with a foreign req
    s3("d1_run",  4'b1000, pk(1,0,0,3,0));
    s3("d1_dn",   4'b1000, pk(0,1,0,3,0));
    s3("d1_id",   4'b1000, 0);
    s3("d1_run2", 4'b1000, pk(1,0,0,3,0));
    s3("d1_dn2",  4'b1000, pk(0,1,0,3,0));
    s3("d1_id2",  4'b0000, 0);
    s3("d1_pri",  4'b0110, pk(1,0,0,1,0));
    s3("d1_hold", 4'b0000, pk(1,0,0,1,0));
    s3("d1_fgn",  4'b0100, pk(1,0,0,1,0));
    s3("d1_dn3",  4'b0010, pk(0,1,0,1,0));
    s3("d1_id3",  4'b0000, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
